// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 average-or-max pooling over raster-order pixels,
// Depth channels in parallel, with a half-width line buffer and valid/ready flow control.

module pool2x2_lane #(
  parameter int DW    = 16,
  parameter int LB_N  = 14,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             in_fire,
  input  logic             col_odd,
  input  logic             row_odd,
  input  logic             mode,
  input  logic [IDX_W-1:0] idx,
  input  logic [DW-1:0]    x,
  output logic [DW-1:0]    res
);
  logic signed [DW-1:0] h_q, h_d;
  logic signed [DW:0]   lb_q [LB_N];
  logic signed [DW:0]   lb_d [LB_N];
  logic signed [DW-1:0] xs, pair_max, prev_max;
  logic signed [DW:0]   pair_sum, pair, p_prev;
  logic signed [DW+1:0] sum3;

  always_comb begin
    xs       = x;
    pair_sum = {h_q[DW-1], h_q} + {xs[DW-1], xs};
    pair_max = (h_q > xs) ? h_q : xs;
    // Line buffer holds the full DW+1 sum in avg mode, a sign-extended max otherwise.
    pair     = mode ? {pair_max[DW-1], pair_max} : pair_sum;
    p_prev   = lb_q[idx];
    prev_max = p_prev[DW-1:0];
    sum3     = {p_prev[DW], p_prev} + {pair_sum[DW], pair_sum};
    // Dropping the two LSBs of the sign-extended sum is a floor divide by 4.
    res      = mode ? ((prev_max > pair_max) ? prev_max : pair_max) : sum3[DW+1:2];
    h_d      = h_q;
    lb_d     = lb_q;
    if (in_fire && !col_odd) h_d = xs;
    if (in_fire && col_odd && !row_odd) lb_d[idx] = pair;
  end

  // Data-path state only; its contents never matter before being written in a frame.
  always_ff @(posedge clk) begin
    h_q  <= h_d;
    lb_q <= lb_d;
  end
endmodule

module pool2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int InputH     = 28,
  parameter int InputW     = 28,
  parameter int Depth      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pool_mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [Depth*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [Depth*DATA_WIDTH-1:0] out_data,
  output logic                        frame_done
);
  localparam int LB_N  = InputW / 2;
  localparam int IDX_W = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam int CW    = $clog2(InputW);
  localparam int RW    = $clog2(InputH);
  localparam logic [CW-1:0] COL_LAST = CW'(InputW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(InputH - 1);

  if ((InputH % 2) != 0 || (InputW % 2) != 0) begin : g_dim_err
    $error("pool2x2_stream: InputH and InputW must be even");
  end

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          frame_done_q, frame_done_d;
  logic [Depth-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d, res;
  logic          in_fire, win;
  logic [IDX_W-1:0] idx;

  assign in_ready   = !out_valid_q || out_ready;
  assign in_fire    = in_valid && in_ready;
  assign win        = in_fire && col_q[0] && row_q[0];
  assign idx        = IDX_W'(col_q >> 1);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

  for (genvar c = 0; c < Depth; c++) begin : g_lane
    pool2x2_lane #(.DW(DATA_WIDTH), .LB_N(LB_N), .IDX_W(IDX_W)) u_lane (
      .clk     (clk),
      .in_fire (in_fire),
      .col_odd (col_q[0]),
      .row_odd (row_q[0]),
      .mode    (mode_q),
      .idx     (idx),
      .x       (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .res     (res[c])
    );
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = out_valid_q && out_ready && out_last_q;
    if (in_fire) begin
      if (col_q == '0 && row_q == '0) mode_d = pool_mode;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    // A new window result wins over the drain of the previous one.
    if (win) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
      out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream on a 4x4, two-channel frame: directed frame table,
// stall/reset sequences and random frames against a window-level scoreboard.

module tb_pool2x2_stream;
  localparam int DW = 16;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int D  = 2;
  localparam int NP = H * W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pool_mode = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [D*DW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [D*DW-1:0] out_data;
  logic frame_done;

  pool2x2_stream #(.DATA_WIDTH(DW), .InputH(H), .InputW(W), .Depth(D)) dut (
    .clk(clk), .reset(reset), .pool_mode(pool_mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int or_mode = 0;  // 0 always ready, 1 toggle, 2 stalled, 3 random

  typedef struct { logic [31:0] data; logic last; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  int  mp0[NP], mp1[NP];
  int  mk = 0;
  logic mmode = 1'b0;
  logic fd_exp = 1'b0;
  int  fd_cnt = 0;

  typedef struct {
    logic mode;
    int   orm;
    logic [15:0] p0[NP];
    logic [15:0] p1[NP];
    logic [15:0] e0[4];
    logic [15:0] e1[4];
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference: pooled value of one 2x2 window straight from the four samples.
  function automatic logic [15:0] win(input logic m, input int a, input int b, input int c, input int d);
    int q, s;
    if (m) begin
      q = a;
      if (b > q) q = b;
      if (c > q) q = c;
      if (d > q) q = d;
    end else begin
      s = a + b + c + d;
      q = s / 4;
      if (s < 0 && (s % 4) != 0) q = q - 1;
    end
    return q[15:0];
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic pm);
    exp_t e;
    int r, c;
    if (mk == 0) mmode = pm;
    mp0[mk] = $signed(d[15:0]);
    mp1[mk] = $signed(d[31:16]);
    r = mk / W;
    c = mk % W;
    if ((r % 2) == 1 && (c % 2) == 1) begin
      e.data = {win(mmode, mp1[mk-W-1], mp1[mk-W], mp1[mk-1], mp1[mk]),
                win(mmode, mp0[mk-W-1], mp0[mk-W], mp0[mk-1], mp0[mk])};
      e.last = (mk == NP - 1);
      exp_q.push_back(e);
    end
    mk = (mk + 1) % NP;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mk = 0;
      exp_q.delete();
      got_q.delete();
      fd_exp = 1'b0;
    end else begin
      if (in_valid && in_ready) model_accept(in_data, pool_mode);
      if (fd_exp || frame_done) chk("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
      if (frame_done) fd_cnt++;
      fd_exp = 1'b0;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got=%h want=none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          fd_exp = e.last;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'b0;
        default: out_ready = ($urandom % 3) != 0;
      endcase
    end
  end

  task automatic send_pixel(input logic [15:0] p0, input logic [15:0] p1);
    logic ok;
    ok = 1'b0;
    in_data  = {p1, p0};
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL input_timeout got=stalled want=accepted");
    end
  endtask

  task automatic wait_results(input int n);
    for (int t = 0; t < 400 && got_q.size() < n; t++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_out_data"}, out_data, 32'd0);
    chk({nm, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_entry(input int v);
    int fd0;
    got_q.delete();
    fd0 = fd_cnt;
    or_mode = tbl[v].orm;
    for (int k = 0; k < NP; k++) begin
      pool_mode = (k == 0) ? tbl[v].mode : ~tbl[v].mode;
      send_pixel(tbl[v].p0[k], tbl[v].p1[k]);
    end
    in_valid = 1'b0;
    wait_results(4);
    chk($sformatf("tbl%0d_count", v), got_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("tbl%0d_res%0d", v, i), got_q[i], {tbl[v].e1[i], tbl[v].e0[i]});
    chk($sformatf("tbl%0d_fd", v), fd_cnt - fd0, 32'd1);
    or_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    logic [15:0] a, b;

    for (int i = 0; i < NP; i++) begin
      tbl[0].p0[i] = 16'(i);           tbl[0].p1[i] = 16'(15 - i);
      tbl[1].p0[i] = 16'(i);           tbl[1].p1[i] = 16'(15 - i);
      tbl[2].p0[i] = (i == 0) ? 16'hFFFF : 16'hFFFE;
      tbl[2].p1[i] = 16'h7FFF;
      tbl[3].p0[i] = 16'(-i);          tbl[3].p1[i] = 16'h8000;
      tbl[4].p0[i] = 16'(i);           tbl[4].p1[i] = 16'(15 - i);
    end
    tbl[0].mode = 1'b0; tbl[0].orm = 0;
    tbl[0].e0 = '{16'd2, 16'd4, 16'd10, 16'd12};  tbl[0].e1 = '{16'd12, 16'd10, 16'd4, 16'd2};
    tbl[1].mode = 1'b1; tbl[1].orm = 0;
    tbl[1].e0 = '{16'd5, 16'd7, 16'd13, 16'd15}; tbl[1].e1 = '{16'd15, 16'd13, 16'd7, 16'd5};
    tbl[2].mode = 1'b0; tbl[2].orm = 0;
    tbl[2].e0 = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
    tbl[2].e1 = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[3].mode = 1'b1; tbl[3].orm = 1;
    tbl[3].e0 = '{16'h0000, 16'hFFFE, 16'hFFF8, 16'hFFF6};
    tbl[3].e1 = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    tbl[4] = tbl[0];
    tbl[4].orm = 1;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 5; v++) run_entry(v);

    // Stall on the first result: nothing may be consumed and the result must hold.
    got_q.delete();
    fd0 = fd_cnt;
    pool_mode = 1'b0;
    for (int k = 0; k < 6; k++) send_pixel(16'(k), 16'(15 - k));
    or_mode = 2;
    in_valid = 1'b1;
    in_data  = {16'(15 - 6), 16'd6};
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_data", out_data, {16'd12, 16'd2});
      @(posedge clk); #1;
    end
    or_mode = 0;
    for (int k = 6; k < NP; k++) begin
      pool_mode = k[0];
      send_pixel(16'(k), 16'(15 - k));
    end
    in_valid = 1'b0;
    wait_results(4);
    chk("stall_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("stall_res%0d", i), got_q[i], {tbl[0].e1[i], tbl[0].e0[i]});
    chk("stall_fd", fd_cnt - fd0, 32'd1);

    // Reset mid-frame with a result pending, then a fresh max frame.
    pool_mode = 1'b0;
    for (int k = 0; k < 6; k++) send_pixel(16'(k), 16'(15 - k));
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    run_entry(1);

    // Random back-to-back frames with random gaps, extremes and backpressure.
    got_q.delete();
    fd0 = fd_cnt;
    or_mode = 3;
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < NP; k++) begin
        pool_mode = 1'($urandom);
        a = (($urandom % 4) == 0) ? (($urandom % 2) ? 16'h7FFF : 16'h8000) : 16'($urandom);
        b = (($urandom % 4) == 0) ? (($urandom % 2) ? 16'h7FFF : 16'h8000) : 16'($urandom);
        if (($urandom % 5) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
        send_pixel(a, b);
      end
    end
    in_valid = 1'b0;
    wait_results(40);
    or_mode = 0;
    repeat (4) @(posedge clk); #1;
    chk("rand_count", got_q.size(), 32'd40);
    chk("rand_fd", fd_cnt - fd0, 32'd10);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool2x2_stream.md
Name: pool2x2_stream

Overview:
- Streaming 2x2/stride-2 pooling stage for the CNN datapath.
- Accepts one pixel per cycle in raster order, with all Depth channels in parallel.
- Emits one pooled pixel per 2x2 window, average or max selectable per frame.
- Replaces the flat combinational pool arrays: needs a line buffer of InputW/2 entries instead of a full frame bus, and uses valid/ready backpressure.

Parameters:
- DATA_WIDTH, 16, bits per channel sample; signed two's complement.
- InputH, 28, frame rows; must be even (elaboration error otherwise).
- InputW, 28, frame columns; must be even (elaboration error otherwise).
- Depth, 1, channels carried in parallel per pixel.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pool_mode  in  1  0 = average, 1 = max; sampled on the first accepted pixel of each frame.
- in_valid  in  1  in_data holds a pixel.
- in_ready  out  1  block can accept a pixel this cycle.
- in_data  in  Depth*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_data holds a pooled pixel.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  Depth*DATA_WIDTH  pooled pixel, same channel packing as in_data.
- frame_done  out  1  one-cycle pulse when the last pooled pixel of a frame is accepted downstream.

Behaviour:
- Reset (async, immediate):
  - Outputs: out_valid=0, out_data=0, frame_done=0, in_ready=1.
  - Internal: row/col counters=0, latched mode=0; line buffer contents don't-care.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
- in_ready = !out_valid || out_ready, combinational. Full throughput of 1 pixel/cycle when out_ready stays high.
- Counters: col runs 0..InputW-1, row runs 0..InputH-1, both advancing on input transfer only.
  - col wraps to 0 and row increments at col = InputW-1.
  - At row = InputH-1 and col = InputW-1, both wrap to 0. The next pixel starts a new frame with no idle cycle.
- Mode latch: at input transfer with row=0, col=0, latch pool_mode. Changes to pool_mode mid-frame are ignored.
- Per channel, independent arithmetic:
  - Even col: hold the pixel in the horizontal register h.
  - Odd col, even row: write pair result p to linebuf[col/2].
    - avg: p = h + x, DATA_WIDTH+1 bits, sign-extended.
    - max: p = signed max(h, x).
  - Odd col, odd row: compute the window result from p = linebuf[col/2] and the current pair; load it into out_data; set out_valid=1 on the next edge.
    - avg: (p + h + x) in DATA_WIDTH+2 bits, arithmetic shift right 2 (floor toward -inf), truncated to DATA_WIDTH. The result is always in range.
    - max: signed max of p and max(h, x).
- Latency: out_valid rises 1 cycle after the input transfer of pixel (2i+1, 2j+1).
- Output order: raster order of the (InputH/2)x(InputW/2) result grid.
- Output register: out_data/out_valid hold stable while out_valid && !out_ready. Output transfer with no new window result in the same cycle clears out_valid.
- Simultaneous output transfer and new window result: out_valid stays 1 and out_data updates to the new result.
- Backpressure: while out_valid && !out_ready, in_ready=0 and no counter or buffer changes. in_valid may be high without effect.
- frame_done: asserted the cycle after the output transfer of result index (InputH/2-1, InputW/2-1).
- Reset mid-frame: partial frame discarded. The next accepted pixel is (0,0) of a new frame.

Test Plan:
- Avg, InputH=InputW=4, Depth=1, pixel values 0..15 raster, out_ready=1 → out_data 2, 4, 10, 12 in order; frame_done pulses once, one cycle after the 4th transfer.
- Max, same frame as above → 5, 7, 13, 15.
- Avg negative floor, one window {-1, -2, -2, -2} → sum -7 >>> 2 = -2 (0xFFFE). Window {32767 x4} → 32767, with no overflow.
- Depth=2, ch0 = 0..15 and ch1 = 15-ch0, mode max, InputH=InputW=4 → ch1 outputs 15, 13, 7, 5; ch0 as in the max test.
- Backpressure: out_ready=0 for 5 cycles when the first result appears → in_ready=0, out_data holds 2, no extra pixels consumed; results resume unchanged afterwards. Toggling out_ready every cycle still yields the exact sequence 2, 4, 10, 12.
- pool_mode toggled mid-frame → ignored. Reset asserted after 6 pixels, then a full fresh frame → only that frame's 4 correct results, and frame_done pulses once.
